jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank.sv | 95 +++++++++
 tb/tb_jk_reg_bank.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/jk_reg_bank.sv
// Bank of NBITS independent JK flip-flops with parallel load, a registered change flag
// and an optional saturating change-event counter (built when JK_REG_BANK_CNT_EN is defined).

module jk_reg_bank_lane #(
    parameter logic RST = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic j,
    input  logic k,
    input  logic ld,
    input  logic ld_d,
    output logic q,
    output logic flip
);
    logic nxt;

    always_comb begin
        nxt = q;
        if (ld) begin
            nxt = ld_d;
        end else if (en) begin
            unique case ({j, k})
                2'b00:   nxt = q;
                2'b01:   nxt = 1'b0;
                2'b10:   nxt = 1'b1;
                default: nxt = ~q;
            endcase
        end
    end

    // Tells the top whether this lane is about to change at the coming edge.
    assign flip = nxt ^ q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= RST;
        else          q <= nxt;
    end
endmodule

module jk_reg_bank #(
    parameter int               NBITS     = 8,
    parameter logic [NBITS-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [NBITS-1:0] j,
    input  logic [NBITS-1:0] k,
    input  logic             ld,
    input  logic [NBITS-1:0] ld_data,
    input  logic             cnt_clr,
    output logic [NBITS-1:0] q,
    output logic             chg,
    output logic [CNT_W-1:0] cnt
);
    logic [NBITS-1:0] flip;
    logic             any_chg;

    for (genvar i = 0; i < NBITS; i++) begin : g_lane
        jk_reg_bank_lane #(.RST(RESET_VAL[i])) u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (en),
            .j       (j[i]),
            .k       (k[i]),
            .ld      (ld),
            .ld_d    (ld_data[i]),
            .q       (q[i]),
            .flip    (flip[i])
        );
    end

    assign any_chg = |flip;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chg <= 1'b0;
        else          chg <= any_chg;
    end

`ifdef JK_REG_BANK_CNT_EN
    // Clear wins over a same-edge increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                  cnt <= '0;
        else if (cnt_clr)              cnt <= '0;
        else if (any_chg && cnt != '1) cnt <= cnt + 1'b1;
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt            = '0;
`endif
endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed bench for jk_reg_bank: default build, CNT_W=2 saturation and RESET_VAL=8'h81 instances.
module tb_jk_reg_bank;
`ifdef JK_REG_BANK_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic [7:0] j, k, ld_data;
    logic       ld, cnt_clr;

    logic [7:0]  q0, q1, q2;
    logic        chg0, chg1, chg2;
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt1;

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    jk_reg_bank u0 (
        .clk(clk), .reset_n(reset_n), .en(en), .j(j), .k(k), .ld(ld), .ld_data(ld_data),
        .cnt_clr(cnt_clr), .q(q0), .chg(chg0), .cnt(cnt0)
    );
    jk_reg_bank #(.CNT_W(2)) u1 (
        .clk(clk), .reset_n(reset_n), .en(en), .j(j), .k(k), .ld(ld), .ld_data(ld_data),
        .cnt_clr(cnt_clr), .q(q1), .chg(chg1), .cnt(cnt1)
    );
    jk_reg_bank #(.RESET_VAL(8'h81)) u2 (
        .clk(clk), .reset_n(reset_n), .en(en), .j(j), .k(k), .ld(ld), .ld_data(ld_data),
        .cnt_clr(cnt_clr), .q(q2), .chg(chg2), .cnt(cnt2)
    );

    function automatic logic [31:0] ec(input int v);
        return CNT_ON ? 32'(v) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic e, input logic [7:0] jj, input logic [7:0] kk,
                       input logic l, input logic [7:0] ld_v, input logic clr);
        en = e; j = jj; k = kk; ld = l; ld_data = ld_v; cnt_clr = clr;
    endtask

    task automatic chk0(input string tag, input logic [7:0] eq, input logic ech, input int ecnt);
        chk({tag, ".q"},   32'(q0), 32'(eq));
        chk({tag, ".chg"}, 32'(chg0), 32'(ech));
        chk({tag, ".cnt"}, 32'(cnt0), ec(ecnt));
    endtask

    initial begin
        reset_n = 1'b0;
        drv(0, 8'h00, 8'h00, 0, 8'h00, 0);
        #12;
        chk0("reset", 8'h00, 0, 0);
        chk("reset.q_rv", 32'(q2), 32'h81);

        reset_n = 1'b1;
        drv(1, 8'hFF, 8'h00, 0, 8'h00, 0);
        tick(); chk0("set_all", 8'hFF, 1, 1);
        drv(1, 8'h00, 8'h00, 0, 8'h00, 0);
        tick(); chk0("hold", 8'hFF, 0, 1);
        drv(0, 8'h00, 8'h00, 1, 8'hA5, 0);
        tick(); chk0("load_a5", 8'hA5, 1, 2);
        drv(1, 8'hFF, 8'hFF, 0, 8'h00, 0);
        tick(); chk0("toggle1", 8'h5A, 1, 3);
        tick(); chk0("toggle2", 8'hA5, 1, 4);
        drv(0, 8'h00, 8'h00, 1, 8'h0F, 0);
        tick(); chk0("load_0f", 8'h0F, 1, 5);
        drv(1, 8'hFF, 8'h00, 1, 8'h3C, 0);
        tick(); chk0("ld_over_jk", 8'h3C, 1, 6);
        drv(0, 8'h00, 8'h00, 1, 8'h3C, 0);
        tick(); chk0("ld_same", 8'h3C, 0, 6);
        drv(0, 8'hFF, 8'hFF, 0, 8'h00, 0);
        tick(); chk0("en_off", 8'h3C, 0, 6);
        // Per-lane mix: set, set, hold, hold, clear, clear, toggle, toggle.
        drv(1, 8'hC3, 8'h0F, 0, 8'h00, 0);
        tick(); chk0("mixed", 8'hF3, 1, 7);
        drv(0, 8'h00, 8'h00, 0, 8'h00, 1);
        tick(); chk0("clr_idle", 8'hF3, 0, 0);
        chk("clr_idle.cnt1", 32'(cnt1), ec(0));

        drv(1, 8'hFF, 8'hFF, 0, 8'h00, 0);
        tick(); chk("sat1.cnt1", 32'(cnt1), ec(1)); chk("sat1.q", 32'(q1), 32'h0C);
        tick(); chk("sat2.cnt1", 32'(cnt1), ec(2));
        tick(); chk("sat3.cnt1", 32'(cnt1), ec(3));
        tick(); chk("sat4.cnt1", 32'(cnt1), ec(3));
        tick(); chk("sat5.cnt1", 32'(cnt1), ec(3)); chk0("sat5.u0", 8'h0C, 1, 5);
        drv(1, 8'hFF, 8'hFF, 0, 8'h00, 1);
        tick();
        chk("clr_tgl.cnt1", 32'(cnt1), ec(0));
        chk("clr_tgl.chg1", 32'(chg1), 32'd1);
        chk0("clr_tgl.u0", 8'hF3, 1, 0);

        drv(1, 8'h00, 8'h00, 1, 8'h00, 0);
        chk("pre_rst.q2", 32'(q2), 32'hF3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst.q2", 32'(q2), 32'h81);
        chk("async_rst.chg2", 32'(chg2), 32'd0);
        chk("async_rst.cnt2", 32'(cnt2), 32'd0);
        tick();
        chk("rst_hold.q2", 32'(q2), 32'h81);
        chk("rst_hold.q0", 32'(q0), 32'h00);
        reset_n = 1'b1;
        drv(0, 8'hFF, 8'h00, 0, 8'h00, 0);
        tick();
        chk("post_rst.q2", 32'(q2), 32'h81);
        chk("post_rst.chg2", 32'(chg2), 32'd0);
        chk("post_rst.cnt2", 32'(cnt2), ec(0));
        drv(1, 8'hFF, 8'h00, 0, 8'h00, 0);
        tick();
        chk("post_set.q2", 32'(q2), 32'hFF);
        chk("post_set.cnt2", 32'(cnt2), ec(1));
        chk0("post_set.u0", 8'hFF, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
